// File: rtl/mul_rr_sequencer_if.sv
// Bundles the signals that connect the shared multiplier sequencer to its two
// requesters and to the repeated-addition datapath.
interface mul_rr_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [WIDTH-1:0] data_in;
    logic             LdA;
    logic             LdB;
    logic             LdP;
    logic             clrP;
    logic             decB;
    logic             eqz;
    logic [WIDTH-1:0] prod_in;

    // Sequencer side
    modport master (
        input  req0, a0, b0, req1, a1, b1, eqz, prod_in,
        output ack0, ack1, result, busy, data_in, LdA, LdB, LdP, clrP, decB
    );

    // Requesters plus datapath side
    modport slave (
        output req0, a0, b0, req1, a1, b1, eqz, prod_in,
        input  ack0, ack1, result, busy, data_in, LdA, LdB, LdP, clrP, decB
    );
endinterface

// File: rtl/mul_rr_sequencer.sv
// Round-robin controller sharing one repeated-addition multiplier datapath
// between two requesters; returns a registered product with a one-cycle ack.
module mul_rr_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    mul_rr_sequencer_if.master  bus
);
    localparam int unsigned W = WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MULT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    logic           ptr;      // 1: requester 1 has priority on a tie
    logic           owner;    // requester that owns the running job
    logic [W-1:0]   b_lat;
    logic           grant1_c;

    always_comb begin
        grant1_c = bus.req1 && (!bus.req0 || ptr);
    end

    // Accumulate strobes follow eqz within the same MULT cycle
    assign bus.LdP  = (state == MULT) && !bus.eqz;
    assign bus.decB = (state == MULT) && !bus.eqz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            b_lat       <= '0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.result  <= '0;
            bus.busy    <= 1'b0;
            bus.data_in <= '0;
            bus.LdA     <= 1'b0;
            bus.LdB     <= 1'b0;
            bus.clrP    <= 1'b0;
        end else begin
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.data_in <= '0;
            bus.LdA     <= 1'b0;
            bus.LdB     <= 1'b0;
            bus.clrP    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner       <= grant1_c;
                        ptr         <= !grant1_c;
                        b_lat       <= grant1_c ? bus.b1 : bus.b0;
                        bus.data_in <= grant1_c ? bus.a1 : bus.a0;
                        bus.LdA     <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    bus.data_in <= b_lat;
                    bus.LdB     <= 1'b1;
                    bus.clrP    <= 1'b1;
                    state       <= LOAD_B;
                end
                LOAD_B: begin
                    state <= MULT;
                end
                MULT: begin
                    if (bus.eqz) begin
                        bus.result <= bus.prod_in;
                        bus.ack0   <= !owner;
                        bus.ack1   <= owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_rr_sequencer.sv
// Directed bench for mul_rr_sequencer with a behavioural A/B/P datapath model.
module tb_mul_rr_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_rr_sequencer_if #(.WIDTH(W)) bus ();

    mul_rr_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Repeated-addition datapath the sequencer drives
    logic [W-1:0] ma = '0, mb = '0, mp = '0;
    always @(posedge clk) begin
        if (bus.LdA) ma <= bus.data_in;
        if (bus.LdB) mb <= bus.data_in;
        else if (bus.decB) mb <= mb - 16'd1;
        if (bus.clrP) mp <= '0;
        else if (bus.LdP) mp <= mp + ma;
    end
    assign bus.eqz     = (mb == '0);
    assign bus.prod_in = mp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           side;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    vec_t vecs [7];

    bit           got_side [4];
    logic [W-1:0] got_res  [4];
    int           got_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single job from one side; called just after a negedge (that cycle is cycle 0)
    task automatic run_single(input vec_t v);
        int lat = -1;
        int ldp = 0;
        bit wrong = 1'b0;
        int lim = int'(v.b) + 20;
        if (v.side) begin bus.req1 = 1'b1; bus.a1 = v.a; bus.b1 = v.b; end
        else        begin bus.req0 = 1'b1; bus.a0 = v.a; bus.b0 = v.b; end
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                bus.a0 = ~v.a; bus.b0 = ~v.b; bus.a1 = ~v.a; bus.b1 = ~v.b;
            end
            if (bus.LdA) check("data_in_a", 64'(bus.data_in), 64'(v.a));
            if (bus.LdB) check("data_in_b", 64'(bus.data_in), 64'(v.b));
            if (bus.LdP) ldp++;
            if ((v.side && bus.ack0) || (!v.side && bus.ack1)) wrong = 1'b1;
            if ((v.side && bus.ack1) || (!v.side && bus.ack0)) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("result", 64'(bus.result), 64'(v.exp_res));
        check("ldp_count", 64'(ldp), 64'(v.b));
        check("other_ack", 64'(wrong), 64'd0);
        @(negedge clk);
        check("busy_after", 64'(bus.busy), 64'd0);
    endtask

    // Collect up to n acks; optionally drop the acked side's req
    task automatic run_multi(input int n, input bit drop);
        got_n = 0;
        for (int k = 0; k < 400 && got_n < n; k++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got_side[got_n] = bus.ack1;
                got_res[got_n]  = bus.result;
                got_n++;
                if (drop) begin
                    if (bus.ack0) bus.req0 = 1'b0;
                    if (bus.ack1) bus.req1 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'd17,    16'd5,   16'd85,    9};
        vecs[1] = '{1'b1, 16'd9,     16'd0,   16'd0,     4};
        vecs[2] = '{1'b0, 16'd300,   16'd300, 16'd24464, 304};
        vecs[3] = '{1'b1, 16'd255,   16'd255, 16'd65025, 259};
        vecs[4] = '{1'b0, 16'd0,     16'd7,   16'd0,     11};
        vecs[5] = '{1'b1, 16'd65535, 16'd2,   16'd65534, 6};
        vecs[6] = '{1'b0, 16'd1000,  16'd70,  16'd4464,  74};

        do_reset();
        check("rst_flags", 64'({bus.busy, bus.ack0, bus.ack1, bus.LdA, bus.LdB,
                                bus.LdP, bus.clrP, bus.decB}), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_data_in", 64'(bus.data_in), 64'd0);

        foreach (vecs[i]) run_single(vecs[i]);

        // Simultaneous requests right after reset: req0 first
        do_reset();
        bus.req0 = 1'b1; bus.a0 = 16'd3; bus.b0 = 16'd4;
        bus.req1 = 1'b1; bus.a1 = 16'd6; bus.b1 = 16'd7;
        run_multi(2, 1'b1);
        check("tie_count", 64'(got_n), 64'd2);
        check("tie_side0", 64'(got_side[0]), 64'd0);
        check("tie_res0", 64'(got_res[0]), 64'd12);
        check("tie_side1", 64'(got_side[1]), 64'd1);
        check("tie_res1", 64'(got_res[1]), 64'd42);

        // Both requests held: grants alternate
        do_reset();
        bus.req0 = 1'b1; bus.a0 = 16'd3; bus.b0 = 16'd4;
        bus.req1 = 1'b1; bus.a1 = 16'd6; bus.b1 = 16'd7;
        run_multi(4, 1'b0);
        check("rr_count", 64'(got_n), 64'd4);
        for (int j = 0; j < 4; j++) begin
            check("rr_side", 64'(got_side[j]), 64'(j % 2));
            check("rr_res", 64'(got_res[j]), (j % 2 == 1) ? 64'd42 : 64'd12);
        end

        // Reset while multiplying aborts without ack
        do_reset();
        bus.req0 = 1'b1; bus.a0 = 16'd5; bus.b0 = 16'd10;
        @(negedge clk);
        bus.req0 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_in_mult", 64'(bus.LdP), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_flags", 64'({bus.busy, bus.ack0, bus.ack1, bus.LdA, bus.LdB,
                                bus.LdP, bus.clrP, bus.decB}), 64'd0);
        check("mid_data_in", 64'(bus.data_in), 64'd0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.ack0 || bus.ack1 || bus.busy) seen = 1'b1;
            end
            check("mid_no_ack", 64'(seen), 64'd0);
        end
        run_single('{1'b0, 16'd2, 16'd3, 16'd6, 7});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
